// File: rtl/ascii_num_parser.sv
// ascii_num_parser: turns an ASCII character stream into number tokens.
//
// Each token carries {number, has_num, eol, last} and is queued in a small FIFO.
// Upstream handshake:   i_vld / o_stall (a character is consumed when i_vld && !o_stall).
// Downstream handshake: o_num_vld / i_num_stall (the head is popped when o_num_vld && !i_num_stall).
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   i_char/i_vld/i_last character input; i_last marks the final character of a stream
//   o_stall             character not accepted this cycle
//   o_num/o_has_num/o_eol/o_last/o_num_vld  FIFO head token (zero when the FIFO is empty)
//   i_num_stall         downstream backpressure
//   o_error             sticky flag for an illegal character or accumulator overflow
//
// Optional feature: define ADV_PARSER_SIGNED_EN to accept a leading '-' and emit
// two's-complement numbers. When it is not defined, '-' is an illegal character.
module ascii_num_parser #(
   parameter int unsigned NUM_W = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       i_char,
   input  logic             i_vld,
   input  logic             i_last,
   output logic             o_stall,
   output logic [NUM_W-1:0] o_num,
   output logic             o_has_num,
   output logic             o_eol,
   output logic             o_last,
   output logic             o_num_vld,
   input  logic             i_num_stall,
   output logic             o_error
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned TokW = NUM_W + 3;
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StNum, StNeg, StErr} state_e;

   state_e           state_q, state_d;
   logic [NUM_W-1:0] acc_q, acc_d;
   logic             neg_q, neg_d;
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic [TokW-1:0]  mem_q [DEPTH];

   logic             accept, pop, push, illegal;
   logic             is_digit, is_sep, is_nl, is_cr;
   logic [3:0]       digit;
   logic [NUM_W-1:0] acc_src;
   logic [NUM_W+3:0] mac;
   logic             ovf;
   logic [NUM_W-1:0] tok_num;
   logic             tok_has, tok_eol, tok_last;
   logic [TokW-1:0]  head;

   assign is_digit = (i_char >= 8'h30) && (i_char <= 8'h39);
   assign is_sep   = (i_char == 8'h20) || (i_char == 8'h2C);
   assign is_nl    = (i_char == 8'h0A);
   assign is_cr    = (i_char == 8'h0D);
   assign digit    = i_char[3:0];

   // Only a continuing number feeds the accumulator; a first digit starts from zero.
   assign acc_src = (state_q == StNum) ? acc_q : '0;
   assign mac     = {4'b0, acc_src} * (NUM_W + 4)'(10) + (NUM_W + 4)'(digit);

`ifdef ADV_PARSER_SIGNED_EN
   logic             is_minus, neg_cur;
   logic [NUM_W+3:0] lim;
   assign is_minus = (i_char == 8'h2D);
   assign neg_cur  = (state_q == StNeg) || ((state_q == StNum) && neg_q);
   // Negative numbers may reach one step further than positive ones.
   assign lim      = ((NUM_W + 4)'(1) << (NUM_W - 1)) - (neg_cur ? '0 : (NUM_W + 4)'(1));
   assign ovf      = mac > lim;
`else
   assign ovf      = |mac[NUM_W+3:NUM_W];
`endif

   // Stall from the registered count only; the error state swallows everything.
   assign o_stall = (state_q != StErr) && (count_q == Full);
   assign accept  = i_vld && !o_stall;
   assign pop     = o_num_vld && !i_num_stall;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      push     = 1'b0;
      illegal  = 1'b0;
      tok_num  = '0;
      tok_has  = 1'b0;
      tok_eol  = 1'b0;
      tok_last = 1'b0;
      if (accept && (state_q != StErr)) begin
         if (state_q == StNeg && !is_digit) begin
            illegal = 1'b1;
         end else if (is_digit) begin
            if (ovf) begin
               illegal = 1'b1;
            end else begin
               acc_d   = mac[NUM_W-1:0];
               neg_d   = (state_q == StNeg) || ((state_q == StNum) && neg_q);
               state_d = StNum;
            end
         end else if (is_sep || is_nl) begin
            if (state_q == StNum) begin
               push    = 1'b1;
               tok_num = neg_q ? (NUM_W'(0) - acc_q) : acc_q;
               tok_has = 1'b1;
               tok_eol = is_nl;
            end else if (is_nl) begin
               push    = 1'b1;
               tok_eol = 1'b1;
            end
            state_d = StIdle;
            acc_d   = '0;
            neg_d   = 1'b0;
`ifdef ADV_PARSER_SIGNED_EN
         end else if (is_minus) begin
            if (state_q == StIdle) state_d = StNeg;
            else                   illegal = 1'b1;
`endif
         end else if (!is_cr) begin
            illegal = 1'b1;
         end

         if (illegal) begin
            push    = 1'b0;
            state_d = StErr;
         end else if (i_last) begin
            // End of stream closes whatever is pending, always with exactly one last token.
            if (!push) begin
               push    = 1'b1;
               tok_has = (state_d == StNum);
               tok_num = tok_has ? (neg_d ? (NUM_W'(0) - acc_d) : acc_d) : '0;
            end
            tok_eol  = 1'b1;
            tok_last = 1'b1;
            state_d  = StIdle;
            acc_d    = '0;
            neg_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !push) count_q <= count_q - CntW'(1);
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {tok_num, tok_has, tok_eol, tok_last};
   end

   assign head      = mem_q[rd_ptr_q];
   assign o_num_vld = (count_q != '0);
   assign o_num     = o_num_vld ? head[TokW-1:3] : '0;
   assign o_has_num = o_num_vld && head[2];
   assign o_eol     = o_num_vld && head[1];
   assign o_last    = o_num_vld && head[0];
   assign o_error   = (state_q == StErr);

endmodule

// File: tb/tb_ascii_num_parser.sv
module tb_ascii_num_parser;

   typedef logic [34:0] tok_t;   // {num[31:0], has, eol, last}
   typedef logic [10:0] tok8_t;  // {num[7:0], has, eol, last}

   typedef struct {
      string s;
      bit    l;
      int    n;
      tok_t  t0;
      tok_t  t1;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, vld, lst, nstall, sel8;
   logic [7:0] ch;

   logic        st32, has32, eol32, last32, nv32, err32;
   logic [31:0] num32;
   logic        st8, has8, eol8, last8, nv8, err8;
   logic [7:0]  num8;

   int errors = 0;
   int checks = 0;

   tok_t  got[$];
   tok8_t got8[$];
   vec_t  vecs[$];

   ascii_num_parser #(.NUM_W(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .i_char(ch), .i_vld(vld && !sel8), .i_last(lst),
      .o_stall(st32), .o_num(num32), .o_has_num(has32), .o_eol(eol32), .o_last(last32),
      .o_num_vld(nv32), .i_num_stall(nstall), .o_error(err32)
   );

   ascii_num_parser #(.NUM_W(8), .DEPTH(4)) dut8 (
      .clk(clk), .rst(rst), .i_char(ch), .i_vld(vld && sel8), .i_last(lst),
      .o_stall(st8), .o_num(num8), .o_has_num(has8), .o_eol(eol8), .o_last(last8),
      .o_num_vld(nv8), .i_num_stall(nstall), .o_error(err8)
   );

   // Inputs change just after posedge, so negedge values hold through the next pop edge.
   always @(negedge clk) begin
      if (nv32 && !nstall) got.push_back({num32, has32, eol32, last32});
      if (nv8 && !nstall)  got8.push_back({num8, has8, eol8, last8});
   end

   function automatic tok_t mk(logic [31:0] n, bit h, bit e, bit l);
      return {n, h, e, l};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(logic [7:0] c, bit l);
      int n = 0;
      ch = c; vld = 1'b1; lst = l;
      forever begin
         @(negedge clk);
         if (!(sel8 ? st8 : st32)) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: char %0h still stalled, want accepted", c);
            break;
         end
      end
      @(posedge clk);
      #1;
      vld = 1'b0; lst = 1'b0; ch = 8'h00;
   endtask

   task automatic send_str(string s, bit l);
      for (int i = 0; i < s.len(); i++) send(s[i], l && (i == s.len() - 1));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
      got.delete();
      got8.delete();
   endtask

   task automatic add(string s, bit l, int n, tok_t a, tok_t b);
      vec_t v;
      v.s = s; v.l = l; v.n = n; v.t0 = a; v.t1 = b;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b0; vld = 1'b0; lst = 1'b0; nstall = 1'b0; sel8 = 1'b0; ch = 8'h00;

      add("12 345\n",      0, 2, mk(12, 1, 0, 0),           mk(345, 1, 1, 0));
      add("7\n\n",         0, 2, mk(7, 1, 1, 0),            mk(0, 0, 1, 0));
      add("  ,8,",         0, 1, mk(8, 1, 0, 0),            '0);
      add("0\015\n",       0, 1, mk(0, 1, 1, 0),            '0);
      add("4294967295 ",   0, 1, mk(32'hFFFFFFFF, 1, 0, 0), '0);
      add("007,",          0, 1, mk(7, 1, 0, 0),            '0);
      add("9",             1, 1, mk(9, 1, 1, 1),            '0);
      add("3\n",           1, 1, mk(3, 1, 1, 1),            '0);
      add(" ",             1, 1, mk(0, 0, 1, 1),            '0);
      add("6 1",           1, 2, mk(6, 1, 0, 0),            mk(1, 1, 1, 1));
`ifdef ADV_PARSER_SIGNED_EN
      add("-42 3\n",       0, 2, mk(32'hFFFFFFD6, 1, 0, 0), mk(3, 1, 1, 0));
      add("-2147483648,",  0, 1, mk(32'h80000000, 1, 0, 0), '0);
`endif

      // Reset state
      idle(2);
      chk("rst_stall", st32, 0);
      chk("rst_vld", nv32, 0);
      chk("rst_num", num32, 0);
      chk("rst_flags", {has32, eol32, last32}, 0);
      chk("rst_err", err32, 0);
      rst = 1'b1;
      idle(1);

      // Latency: token visible the cycle after its terminator is accepted
      nstall = 1'b1;
      send("1", 0);
      send("2", 0);
      @(negedge clk);
      chk("lat_before", nv32, 0);
      @(posedge clk); #1;
      send(" ", 0);
      chk("lat_after", nv32, 1);
      chk("lat_head", {num32, has32, eol32, last32}, mk(12, 1, 0, 0));
      nstall = 1'b0;
      idle(3);
      chk("lat_pop", got.size(), 1);
      got.delete();

      // Table vectors, no backpressure
      foreach (vecs[k]) begin
         got.delete();
         send_str(vecs[k].s, vecs[k].l);
         idle(4);
         chk($sformatf("vec%0d_count", k), got.size(), vecs[k].n);
         if (vecs[k].n > 0 && got.size() > 0) chk($sformatf("vec%0d_tok0", k), got[0], vecs[k].t0);
         if (vecs[k].n > 1 && got.size() > 1) chk($sformatf("vec%0d_tok1", k), got[1], vecs[k].t1);
         chk($sformatf("vec%0d_err", k), err32, 0);
      end

      // Backpressure: FIFO fills, stall rises, tokens drain in order
      got.delete();
      nstall = 1'b1;
      send_str("1 2 3 4 ", 0);
      @(negedge clk);
      chk("full_stall", st32, 1);
      chk("full_head", num32, 1);
      @(posedge clk); #1;
      nstall = 1'b0;
      send_str("5 ", 0);
      idle(6);
      chk("drain_count", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++)
         chk($sformatf("drain_%0d", i), got[i], mk(i + 1, 1, 0, 0));

      // Narrow accumulator overflow
      sel8 = 1'b1;
      got8.delete();
      send_str("255 25", 0);
      chk("ovf8_pre", err8, 0);
      send("6", 0);
      chk("ovf8_err", err8, 1);
      send_str(" 1 2\n", 0);
      idle(4);
      chk("ovf8_count", got8.size(), 1);
      if (got8.size() > 0) chk("ovf8_tok", got8[0], {8'd255, 3'b100});
      chk("ovf8_stall", st8, 0);
      sel8 = 1'b0;

      // Illegal character: error, later chars swallowed
      do_reset();
      send("x", 0);
      chk("illegal_err", err32, 1);
      send_str("3 \n", 1);
      idle(3);
      chk("illegal_notok", got.size(), 0);
      chk("illegal_stall", st32, 0);
      do_reset();
      chk("illegal_cleared", err32, 0);

`ifdef ADV_PARSER_SIGNED_EN
      send_str("- ", 0);
      chk("neg_sep_err", err32, 1);
`else
      send("-", 0);
      chk("minus_err", err32, 1);
`endif
      do_reset();

      // 32-bit overflow boundary
      send_str("429496729", 0);
      chk("ovf32_pre", err32, 0);
      send("6", 0);
      chk("ovf32_err", err32, 1);
      do_reset();

      // Asynchronous reset mid-number with a non-empty FIFO
      nstall = 1'b1;
      send_str("5 6", 0);
      chk("arst_pre", nv32, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_vld", nv32, 0);
      chk("arst_num", num32, 0);
      chk("arst_flags", {has32, eol32, last32, err32, st32}, 0);
      idle(2);
      rst = 1'b1;
      nstall = 1'b0;
      idle(1);
      got.delete();
      send_str("8\n", 0);
      idle(4);
      chk("arst_after_count", got.size(), 1);
      if (got.size() > 0) chk("arst_after_tok", got[0], mk(8, 1, 1, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
